mux3_1_rr_merge: RTL
====================

// Module: mux3_1_rr_merge
// PURPOSE
//  Merges three 64-bit lane streams (e.g. three PE result lanes) into one output stream.
//  It is the collecting counterpart of the 1:3 lane demux.
//  - Round-robin burst arbitration over the lanes.
//  - valid/ready handshake on every channel.
//  - Registered output stage.
//  - out_sel carries the source lane in the same 2-bit encoding as the demux select, so the stream can be re-split.
// PARAMETERS
//  DATA_W     64  lane / output data width
//  BURST_LEN  4   max beats per grant, legal range >=2; CNT_W = $clog2(BURST_LEN)
// PORTS
//  clk          in   1         single clock, rising edge
//  rst          in   1         asynchronous, active-high reset
//  in_data_0    in   DATA_W    lane 0 data
//  in_data_1    in   DATA_W    lane 1 data
//  in_data_2    in   DATA_W    lane 2 data
//  in_valid     in   3         per-lane valid, bit i = lane i
//  in_ready     out  3         per-lane ready; at most one bit high (one-hot or zero)
//  out_data     out  DATA_W    merged data (registered)
//  out_sel      out  2         source lane of out_data: 0/1/2; 3 never emitted
//  out_last     out  1         final beat of a full BURST_LEN burst
//  out_valid    out  1         output holds a beat
//  out_ready    in   1         downstream accepts
// BEHAVIOUR
//  Reset (async, immediate):
//   - out_valid=0, out_data=0, out_sel=0, out_last=0, in_ready=0.
//   - state=IDLE, beat_cnt=0, rr_ptr=2, so lane 0 has first priority.
//  Definitions:
//   - slot_free = !out_valid || out_ready.
//   - A beat is accepted on lane i when in_valid[i] && in_ready[i] at a clock edge.
//  FSM IDLE:
//   - in_ready=0.
//   - If any in_valid: grant <= first requesting lane in order rr_ptr+1, rr_ptr+2, rr_ptr (mod 3); beat_cnt<=0; go BURST.
//   - Otherwise stay in IDLE.
//  FSM BURST:
//   - in_ready[grant] = slot_free; all other bits 0.
//   - On accept: out_data<=in_data_grant, out_sel<=grant, out_valid<=1, out_last<=(beat_cnt==BURST_LEN-1), beat_cnt++.
//   - Accepting beat BURST_LEN-1: rr_ptr<=grant; go IDLE.
//   - Early end: slot_free && !in_valid[grant] -> rr_ptr<=grant; go IDLE. No out_last is emitted; the burst is short.
//   - !slot_free: hold state; in_ready=0.
//  Output register:
//   - If out_ready && out_valid and no new accept that cycle: out_valid<=0, out_last<=0.
//   - Simultaneous drain and accept: the new beat replaces the old one; out_valid stays 1.
//   - Data, sel and last are stable while out_valid && !out_ready.
//  Latency and throughput:
//   - First beat: in_valid seen in cycle 0 -> grant in cycle 1 -> out_valid in cycle 2.
//   - Inside a burst: 1 beat/cycle.
//   - Between grants: exactly 1 idle (IDLE) cycle, i.e. one bubble.
//  Fairness: a lane that keeps in_valid high is granted within 2 other bursts.
//  No data is lost or duplicated under any out_ready pattern.
//  Input rule: in_valid may drop only after an accept. The block needs no protection against a violation; the early-end rule handles it.
//  Reset mid-burst: in-flight beat discarded; arbitration restarts with lane 0 priority.
// STRUCTURE
//  Package cnn_mux_pkg:
//   - NUM_LANES=3.
//   - lane_t (2-bit; LANE0=0, LANE1=1, LANE2=2).
//   - state_t {IDLE, BURST}.
//  Sub-module rr_pick3: combinational picker (req[2:0], ptr) -> (any, lane_t grant); reusable by other merge points.
//  Top level holds the FSM, beat counter, rr_ptr, data mux and output register.
// TESTING
//  1. Reset: assert rst mid-cycle -> out_valid=0 and in_ready=000 immediately; after release lane 0 wins first.
//  2. Lane 0 only: 0x11..0x14, out_ready=1 -> out_data 11,12,13,14; out_sel=0; out_last only on 0x14; first out_valid 2 cycles after in_valid.
//  3. All lanes valid, out_ready=1 -> out_sel 0000,1111,2222,0000...; one bubble between bursts; out_last every 4th beat.
//  4. Backpressure: out_ready=0 for 3 cycles after beat 2 -> out_data held, in_ready=000, then beats 3..4 follow in order with no loss or duplicate.
//  5. Early end: lane1 sends 0xA1,0xA2 then drops while lane2 is valid -> sel 1,1 with out_last=0, then lane2 granted.
//  6. Async reset asserted mid-burst with out_valid=1 -> outputs clear that cycle; restarted traffic yields lane 0 burst first.

Source files
------------

// File: rtl/cnn_mux_pkg.sv
// Shared types for the lane merge/demux path: lane encoding, FSM states and
// a helper that steps a lane index round the three-lane ring.
package cnn_mux_pkg;

    localparam int NUM_LANES = 3;

    typedef enum logic [1:0] {
        LANE0 = 2'd0,
        LANE1 = 2'd1,
        LANE2 = 2'd2
    } lane_t;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    // Next lane in ring order 0 -> 1 -> 2 -> 0.
    function automatic lane_t lane_next(input lane_t lane);
        case (lane)
            LANE0:   return LANE1;
            LANE1:   return LANE2;
            default: return LANE0;
        endcase
    endfunction

endpackage

// File: rtl/rr_pick3.sv
// Combinational round-robin picker for three requesters: searches ptr+1,
// ptr+2, ptr (mod 3) and returns the first requesting lane.
module rr_pick3
    import cnn_mux_pkg::*;
(
    input  logic [2:0] req,
    input  lane_t      ptr,
    output logic       any,
    output lane_t      grant
);

    lane_t first;
    lane_t second;

    always_comb begin
        first  = lane_next(ptr);
        second = lane_next(first);
        any    = |req;
        grant  = ptr;
        if (req[first]) begin
            grant = first;
        end else if (req[second]) begin
            grant = second;
        end
    end

endmodule

// File: rtl/mux3_1_rr_merge.sv
// Three-lane to one-stream merge with round-robin burst arbitration and a
// registered output stage; out_sel tags each beat with its source lane.
module mux3_1_rr_merge
    import cnn_mux_pkg::*;
#(
    parameter int DATA_W    = 64,
    parameter int BURST_LEN = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data_0,
    input  logic [DATA_W-1:0] in_data_1,
    input  logic [DATA_W-1:0] in_data_2,
    input  logic [2:0]        in_valid,
    output logic [2:0]        in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        out_sel,
    output logic              out_last,
    output logic              out_valid,
    input  logic              out_ready
);

    localparam int CNT_W = $clog2(BURST_LEN);

    state_t            state;
    lane_t             grant;
    lane_t             rr_ptr;
    logic [CNT_W-1:0]  beat_cnt;

    logic              slot_free;
    logic              burst_open;
    logic              accept;
    logic              last_beat;
    logic              grant_valid;
    logic [DATA_W-1:0] grant_data;
    logic              pick_any;
    lane_t             pick_lane;

    rr_pick3 u_pick (
        .req   (in_valid),
        .ptr   (rr_ptr),
        .any   (pick_any),
        .grant (pick_lane)
    );

    assign slot_free  = !out_valid || out_ready;
    assign burst_open = (state == BURST) && slot_free;

    for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_ready
        assign in_ready[gi] = burst_open && (grant == lane_t'(gi));
    end

    assign accept    = |(in_valid & in_ready);
    assign last_beat = (beat_cnt == CNT_W'(BURST_LEN - 1));

    always_comb begin
        case (grant)
            LANE0: begin
                grant_data  = in_data_0;
                grant_valid = in_valid[0];
            end
            LANE1: begin
                grant_data  = in_data_1;
                grant_valid = in_valid[1];
            end
            default: begin
                grant_data  = in_data_2;
                grant_valid = in_valid[2];
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            grant     <= LANE0;
            rr_ptr    <= LANE2;
            beat_cnt  <= '0;
            out_data  <= '0;
            out_sel   <= 2'd0;
            out_last  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        grant    <= pick_lane;
                        beat_cnt <= '0;
                        state    <= BURST;
                    end
                end
                BURST: begin
                    if (accept) begin
                        beat_cnt <= beat_cnt + 1'b1;
                        if (last_beat) begin
                            rr_ptr <= grant;
                            state  <= IDLE;
                        end
                    end else if (slot_free && !grant_valid) begin
                        // Lane went quiet mid-burst: close a short burst without out_last.
                        rr_ptr <= grant;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            if (accept) begin
                out_data  <= grant_data;
                out_sel   <= grant;
                out_last  <= last_beat;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
        end
    end

endmodule
